// File: rtl/timer_multi.sv
// timer_multi: NCH-channel down-counting timer with one-shot/auto-reload modes, sticky pending
// and per-channel IRQ mask. Define TIMER_PRESCALE_EN to add the per-channel 8-bit prescaler.
module timer_multi #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [5:2]     Addr,
    input  logic           we,
    input  logic [31:0]    data_in,
    output logic [31:0]    data_out,
    output logic [NCH-1:0] irq_vec,
    output logic           IRQ
);

    typedef enum logic [1:0] {
        StIdle,
        StCounting,
        StExpire
    } state_e;

    localparam logic [1:0] RegCtrl    = 2'd0;
    localparam logic [1:0] RegPreset  = 2'd1;
    localparam logic [1:0] RegCount   = 2'd2;
    localparam logic [1:0] RegStatus  = 2'd3;
    localparam logic [1:0] ModeReload = 2'b01;

    state_e           r_state   [NCH];
    logic             r_en      [NCH];
    logic [1:0]       r_mode    [NCH];
    logic             r_im      [NCH];
    logic [CNT_W-1:0] r_preset  [NCH];
    logic [CNT_W-1:0] r_count   [NCH];
    logic             r_pend    [NCH];

    state_e           w_state_d [NCH];
    logic             w_en_d    [NCH];
    logic [1:0]       w_mode_d  [NCH];
    logic             w_im_d    [NCH];
    logic [CNT_W-1:0] w_preset_d[NCH];
    logic [CNT_W-1:0] w_count_d [NCH];
    logic             w_pend_d  [NCH];
    logic             w_set     [NCH];

    logic             w_wr_ctrl  [NCH];
    logic             w_wr_preset[NCH];
    logic             w_wr_status[NCH];
    logic             w_tick     [NCH];
    logic [7:0]       w_psc_rd   [NCH];
    logic             w_unused_data;

`ifdef TIMER_PRESCALE_EN
    logic [7:0]       r_psc      [NCH];
    logic [7:0]       r_psc_cnt  [NCH];
    logic [7:0]       w_psc_d    [NCH];
    logic [7:0]       w_psc_cnt_d[NCH];
`endif

    // Only a few data_in bits are architected; fold the rest so nothing dangles.
    assign w_unused_data = ^data_in;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_wr_ctrl[i]   = we && (Addr[5:4] == 2'(i)) && (Addr[3:2] == RegCtrl);
            w_wr_preset[i] = we && (Addr[5:4] == 2'(i)) && (Addr[3:2] == RegPreset);
            w_wr_status[i] = we && (Addr[5:4] == 2'(i)) && (Addr[3:2] == RegStatus);
`ifdef TIMER_PRESCALE_EN
            w_tick[i]      = (r_psc_cnt[i] == r_psc[i]);
            w_psc_rd[i]    = r_psc[i];
`else
            w_tick[i]      = 1'b1;
            w_psc_rd[i]    = 8'd0;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_d[i]  = r_state[i];
            w_en_d[i]     = r_en[i];
            w_mode_d[i]   = r_mode[i];
            w_im_d[i]     = r_im[i];
            w_preset_d[i] = r_preset[i];
            w_count_d[i]  = r_count[i];
            w_pend_d[i]   = r_pend[i];
            w_set[i]      = 1'b0;
            // A CTRL/PRESET write parks the channel in IDLE; the FSM does not act that cycle.
            if (w_wr_ctrl[i]) begin
                w_en_d[i]    = data_in[0];
                w_mode_d[i]  = data_in[2:1];
                w_im_d[i]    = data_in[3];
                w_state_d[i] = StIdle;
            end else if (w_wr_preset[i]) begin
                w_preset_d[i] = data_in[CNT_W-1:0];
                w_state_d[i]  = StIdle;
            end else begin
                case (r_state[i])
                    StIdle: begin
                        if (r_en[i]) begin
                            w_count_d[i] = r_preset[i];
                            if (r_preset[i] == '0) begin
                                w_state_d[i] = StExpire;
                                w_set[i]     = 1'b1;
                            end else begin
                                w_state_d[i] = StCounting;
                            end
                        end
                    end
                    StCounting: begin
                        if (!r_en[i]) begin
                            w_state_d[i] = StIdle;
                        end else if (w_tick[i]) begin
                            w_count_d[i] = r_count[i] - CNT_W'(1);
                            if (r_count[i] == CNT_W'(1)) begin
                                w_state_d[i] = StExpire;
                                w_set[i]     = 1'b1;
                            end
                        end
                    end
                    StExpire: begin
                        if (r_mode[i] == ModeReload) begin
                            w_count_d[i] = r_preset[i];
                            if (r_preset[i] == '0) begin
                                w_set[i] = 1'b1;
                            end else begin
                                w_state_d[i] = StCounting;
                            end
                        end else begin
                            w_en_d[i]    = 1'b0;
                            w_state_d[i] = StIdle;
                        end
                    end
                    default: w_state_d[i] = StIdle;
                endcase
            end
            // Set takes priority over a simultaneous write-1-to-clear.
            if (w_wr_status[i] && data_in[0]) w_pend_d[i] = 1'b0;
            if (w_set[i]) w_pend_d[i] = 1'b1;
        end
    end

`ifdef TIMER_PRESCALE_EN
    // Held at zero outside COUNTING, so entry into COUNTING always starts a fresh period.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_psc_d[i] = w_wr_ctrl[i] ? data_in[15:8] : r_psc[i];
            if (w_wr_ctrl[i] || w_wr_preset[i] || r_state[i] != StCounting) begin
                w_psc_cnt_d[i] = 8'd0;
            end else begin
                w_psc_cnt_d[i] = w_tick[i] ? 8'd0 : r_psc_cnt[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_psc[i]     <= 8'd0;
                r_psc_cnt[i] <= 8'd0;
            end else begin
                r_psc[i]     <= w_psc_d[i];
                r_psc_cnt[i] <= w_psc_cnt_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_state[i]  <= StIdle;
                r_en[i]     <= 1'b0;
                r_mode[i]   <= 2'b00;
                r_im[i]     <= 1'b0;
                r_preset[i] <= '0;
                r_count[i]  <= '0;
                r_pend[i]   <= 1'b0;
            end else begin
                r_state[i]  <= w_state_d[i];
                r_en[i]     <= w_en_d[i];
                r_mode[i]   <= w_mode_d[i];
                r_im[i]     <= w_im_d[i];
                r_preset[i] <= w_preset_d[i];
                r_count[i]  <= w_count_d[i];
                r_pend[i]   <= w_pend_d[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (Addr[5:4] == 2'(i)) begin
                case (Addr[3:2])
                    RegCtrl:   data_out = {16'd0, w_psc_rd[i], 4'd0, r_im[i], r_mode[i], r_en[i]};
                    RegPreset: data_out = 32'(r_preset[i]);
                    RegCount:  data_out = 32'(r_count[i]);
                    default:   data_out = {31'd0, r_pend[i]};
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            irq_vec[i] = r_pend[i] & r_im[i];
        end
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi (NCH=2, CNT_W=8): directed test-plan steps plus random bus traffic,
// every cycle compared against a closed-form timing model of each channel.
module tb_timer_multi;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    logic           clk;
    logic           reset;
    logic [3:0]     Addr;
    logic           we;
    logic [31:0]    data_in;
    logic [31:0]    data_out;
    logic [NCH-1:0] irq_vec;
    logic           IRQ;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    logic [31:0] v;

    // Model: configuration captured at the last CTRL/PRESET write plus that write's edge index.
    int m_en[NCH], m_mode[NCH], m_im[NCH], m_psc[NCH], m_preset[NCH], m_base[NCH], m_start[NCH];
    int m_pend[NCH];

    timer_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .we(we), .data_in(data_in),
        .data_out(data_out), .irq_vec(irq_vec), .IRQ(IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    function automatic int tdiv(input int ch);
`ifdef TIMER_PRESCALE_EN
        return m_psc[ch] + 1;
`else
        return 1;
`endif
    endfunction

    // k = cycles since the first edge after the starting write; one period spans p*t+1 edges.
    function automatic int cnt_at(input int ch, input int e);
        int k = e - m_start[ch] - 1;
        int p = m_preset[ch];
        int t = tdiv(ch);
        if (m_en[ch] == 0 || k < 0) return m_base[ch];
        if (m_mode[ch] == 1) return p - (k % (p * t + 1)) / t;
        if (k >= p * t) return 0;
        return p - k / t;
    endfunction

    function automatic int en_at(input int ch, input int e);
        int k = e - m_start[ch] - 1;
        if (m_en[ch] == 0) return 0;
        if (k < 0 || m_mode[ch] == 1) return 1;
        return (k < m_preset[ch] * tdiv(ch) + 1) ? 1 : 0;
    endfunction

    function automatic int set_at(input int ch, input int e);
        int k = e - m_start[ch] - 1;
        int pt = m_preset[ch] * tdiv(ch);
        if (m_en[ch] == 0 || k < 0) return 0;
        if (m_mode[ch] == 1) return ((k % (pt + 1)) == pt) ? 1 : 0;
        return (k == pt) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_psc[i] = 0;
            m_preset[i] = 0; m_base[i] = 0; m_start[i] = edge_n; m_pend[i] = 0;
        end
    endtask

    task automatic model_edge(input logic w, input logic [3:0] a, input logic [31:0] d);
        int setv[NCH];
        int clr[NCH];
        int ch = int'(a[3:2]);
        int rg = int'(a[1:0]);
        int b;
        int en;
        for (int i = 0; i < NCH; i++) begin
            setv[i] = set_at(i, edge_n);
            clr[i]  = 0;
        end
        if (w && ch < NCH) begin
            case (rg)
                0: begin
                    b = cnt_at(ch, edge_n - 1);
                    m_base[ch] = b; m_en[ch] = int'(d[0]); m_mode[ch] = int'(d[2:1]);
                    m_im[ch] = int'(d[3]); m_start[ch] = edge_n; setv[ch] = 0;
`ifdef TIMER_PRESCALE_EN
                    m_psc[ch] = int'(d[15:8]);
`endif
                end
                1: begin
                    b = cnt_at(ch, edge_n - 1);
                    en = en_at(ch, edge_n - 1);
                    m_base[ch] = b; m_en[ch] = en; m_preset[ch] = int'(d[CNT_W-1:0]);
                    m_start[ch] = edge_n; setv[ch] = 0;
                end
                3: clr[ch] = int'(d[0]);
                default: ;
            endcase
        end
        for (int i = 0; i < NCH; i++) begin
            if (setv[i] != 0) m_pend[i] = 1;
            else if (clr[i] != 0) m_pend[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] val);
        Addr = 4'(ch * 4 + r);
        #1;
        val = data_out;
    endtask

    task automatic check_all();
        logic [31:0] exp;
        logic [NCH-1:0] expv;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                Addr = 4'(c * 4 + r);
                #1;
                exp = 0;
                if (c < NCH) begin
                    case (r)
                        0: exp = (m_psc[c] << 8) | (m_im[c] << 3) | (m_mode[c] << 1)
                                 | en_at(c, edge_n);
                        1: exp = m_preset[c];
                        2: exp = cnt_at(c, edge_n);
                        default: exp = m_pend[c];
                    endcase
                end
                chk($sformatf("rd e%0d ch%0d reg%0d", edge_n, c, r), data_out, exp);
            end
        end
        for (int i = 0; i < NCH; i++) expv[i] = (m_pend[i] != 0) && (m_im[i] != 0);
        chk($sformatf("irq_vec e%0d", edge_n), 32'(irq_vec), 32'(expv));
        chk($sformatf("IRQ e%0d", edge_n), 32'(IRQ), 32'(|expv));
    endtask

    task automatic step(input logic w, input logic [3:0] a, input logic [31:0] d);
        we = w; Addr = a; data_in = d;
        @(posedge clk);
        edge_n++;
        model_edge(w, a, d);
        #1;
        we = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0;
        @(posedge clk);
        edge_n++;
        model_reset();
        #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        step(1'b1, 4'(ch * 4 + r), d);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        int ops[9];
        int exps[9];
        int cexp;
        int sexp;
        logic [31:0] d;
        int r;
        reset = 1'b1; we = 1'b0; Addr = 4'd0; data_in = 32'd0;
        model_reset();
        do_reset();
        chk("reset_irq", 32'(IRQ), 32'd0);

        // Reset mid-count
        wr(0, 1, 32'd5); wr(0, 0, 32'h1); idle();
        rd(0, 2, v); chk("midcount_count", v, 32'd5);
        do_reset();
        rd(0, 2, v); chk("rst_count", v, 32'd0);
        rd(0, 1, v); chk("rst_preset", v, 32'd0);
        rd(0, 0, v); chk("rst_ctrl", v, 32'd0);
        chk("rst_irq2", 32'(IRQ), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(); rd(0, 2, v); chk("rst_hold_count", v, 32'd0);
        end

        // One-shot, PRESET=3, IM
        wr(0, 1, 32'd3); wr(0, 0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            idle();
            rd(0, 2, v); chk("os_count", v, 32'(4 - k));
            chk("os_irq", 32'(IRQ), (k == 4) ? 32'd1 : 32'd0);
        end
        idle();
        rd(0, 0, v); chk("os_ctrl_after", v, 32'h8);
        rd(0, 2, v); chk("os_count_hold", v, 32'd0);
        wr(0, 3, 32'd1); chk("os_clr_irq", 32'(IRQ), 32'd0);

        // Auto-reload PRESET=2 on ch1: clear, re-raise, then set/clear collision
        ops  = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
        exps = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        wr(1, 1, 32'd2); wr(1, 0, 32'hB);
        for (int k = 0; k < 9; k++) begin
            if (ops[k] != 0) wr(1, 3, 32'd1);
            else idle();
            chk("ar_irq1", 32'(irq_vec[1]), 32'(exps[k]));
        end
        wr(1, 0, 32'd0); wr(1, 3, 32'd1);

        // IM=0 one-shot PRESET=1
        wr(0, 1, 32'd1); wr(0, 0, 32'h1);
        idle(); idle(); idle();
        rd(0, 3, v); chk("nomask_status", v, 32'd1);
        chk("nomask_vec", 32'(irq_vec), 32'd0);
        chk("nomask_irq", 32'(IRQ), 32'd0);
        wr(0, 3, 32'd1);

        // Out-of-range channel
        wr(3, 1, 32'd5); rd(3, 1, v); chk("ch3_preset", v, 32'd0);
        wr(3, 0, 32'h1); rd(3, 0, v); chk("ch3_ctrl", v, 32'd0);
        rd(2, 2, v); chk("ch2_count", v, 32'd0);

        // PRESET=0 auto-reload: pending every cycle, survives clears
        wr(1, 1, 32'd0); wr(1, 0, 32'hB); idle();
        rd(1, 3, v); chk("p0_status", v, 32'd1);
        for (int k = 0; k < 3; k++) begin
            wr(1, 3, 32'd1); rd(1, 3, v); chk("p0_collide", v, 32'd1);
        end
        wr(1, 0, 32'd0); wr(1, 3, 32'd1);
        rd(1, 3, v); chk("p0_cleared", v, 32'd0);

        // Truncation to CNT_W
        wr(1, 1, 32'h1FF); rd(1, 1, v); chk("preset_trunc", v, 32'hFF);

        // Prescaler (or its absence)
        wr(0, 1, 32'd2); wr(0, 0, 32'h0301);
        rd(0, 0, v);
`ifdef TIMER_PRESCALE_EN
        chk("psc_ctrl", v, 32'h301);
`else
        chk("psc_ctrl", v, 32'h1);
`endif
        for (int k = 1; k <= 9; k++) begin
            idle();
`ifdef TIMER_PRESCALE_EN
            cexp = (k <= 4) ? 2 : (k <= 8) ? 1 : 0;
            sexp = (k >= 9) ? 1 : 0;
`else
            cexp = (k == 1) ? 2 : (k == 2) ? 1 : 0;
            sexp = (k >= 3) ? 1 : 0;
`endif
            rd(0, 2, v); chk("psc_count", v, 32'(cexp));
            rd(0, 3, v); chk("psc_status", v, 32'(sexp));
        end

        // Random bus traffic
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_reset();
            end else if (r < 40) begin
                idle();
            end else begin
                int ch = $urandom_range(0, 3);
                int rg = $urandom_range(0, 3);
                d = $urandom;
                if (rg == 0) begin
                    d[15:8] = 8'($urandom_range(0, 2));
                    d[0] = ($urandom_range(0, 3) != 0);
                end else if (rg == 1 && $urandom_range(0, 9) != 0) begin
                    d = 32'($urandom_range(0, 6));
                end
                wr(ch, rg, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
